rv32_ifetch: RTL
================

// Module: rv32_ifetch
// PURPOSE
//  Instruction-fetch unit directly downstream of the program counter. Takes the PC, runs a
//  req/gnt/rvalid handshake to the instruction SRAM (shared with DMA, so multi-cycle), and
//  holds the fetched word stable for decode. Drives fetch_stall into the PC hold input.
//  Flags misaligned, bus-error and timeout fetch faults.
// PARAMETERS
//  TIMEOUT_CYCLES  64                           max cycles in WAIT before FETCH_TIMEOUT
//  TO_CNT_W        $clog2(TIMEOUT_CYCLES+1)     timeout counter width (derived, do not override)
// PORTS
//  clk           in   1     core clock, rising edge
//  rst_n         in   1     reset, asynchronous assert, active-low
//  fetch_en      in   1     core running; 0 = do not start new fetches
//  pc_in         in   XLEN  current PC from the program counter
//  flush         in   1     1-cycle pulse: PC redirected, discard fetch in progress
//  core_adv      in   1     decode/execute consumed instr this cycle
//  imem_req      out  1     SRAM request
//  imem_addr     out  XLEN  SRAM word address (byte address, [1:0]=0)
//  imem_gnt      in   1     request accepted
//  imem_rvalid   in   1     read data valid
//  imem_rdata    in   32    read data
//  imem_err      in   1     bus error, qualified by imem_rvalid
//  instr         out  32    fetched instruction (NOP_INSTR when faulted)
//  instr_pc      out  XLEN  address of instr
//  instr_valid   out  1     instr/instr_pc/fault_cause valid
//  fault_cause   out  2     fetch_fault_e
//  fetch_stall   out  1     = ~instr_valid; drives the PC stall input
// BEHAVIOUR
//  Reset: state IDLE; imem_req=0, imem_addr=RESET_VECTOR, instr=NOP_INSTR,
//   instr_pc=RESET_VECTOR, instr_valid=0, fault_cause=FETCH_OK, drop=0, timeout counter=0.
//  FSM (fetch_state_e):
//   IDLE:  fetch_en=1 -> capture pc_in. If pc_in[1:0]!=0: instr=NOP_INSTR,
//          fault_cause=FETCH_MISALIGN -> VALID, no request issued. Else imem_addr<=pc_in -> REQ.
//   REQ:   imem_req=1, imem_addr held stable until gnt (req is never withdrawn before gnt).
//          gnt -> WAIT.
//   WAIT:  counter increments each cycle. rvalid & ~drop: instr<=rdata,
//          fault_cause<=imem_err ? FETCH_BUSERR : FETCH_OK (instr=NOP_INSTR on error)
//          -> VALID. Counter reaching TIMEOUT_CYCLES with no rvalid: FETCH_TIMEOUT,
//          instr=NOP_INSTR -> VALID. A late rvalid after timeout is ignored.
//   VALID: instr_valid=1. core_adv -> IDLE; the PC advances on that same edge, so the next
//          IDLE samples the new pc_in.
//  Latency: IDLE->REQ takes 1 cycle. gnt in first REQ cycle plus rvalid on next cycle
//   gives instr_valid 3 cycles after leaving IDLE.
//  flush:
//   IDLE/VALID: -> IDLE, instr_valid drops next cycle.
//   REQ: drop<=1, keep req until gnt.
//   WAIT: drop<=1.
//   Any WAIT with drop=1: the rvalid is discarded, drop<=0 -> IDLE. Timeout also clears drop.
//   flush in the same cycle as rvalid discards that data.
//   flush together with core_adv: flush wins.
//  Outstanding requests never exceed 1. fetch_en=0 stops only IDLE from starting a fetch;
//   an in-flight fetch completes.
//  Async reset mid-transaction: all state cleared immediately. Any SRAM response still
//   pending is the memory's responsibility and is ignored after reset.
//  Widths: counter saturates at TIMEOUT_CYCLES and clears on leaving WAIT. No arithmetic on PC.
// STRUCTURE
//  pkg_rv32_types additions:
//   fetch_state_e {IDLE,REQ,WAIT,VALID}
//   fetch_fault_e {FETCH_OK,FETCH_MISALIGN,FETCH_BUSERR,FETCH_TIMEOUT} (2-bit)
//   NOP_INSTR = 32'h0000_0013
//  XLEN and RESET_VECTOR come from the package.
//  Sub-module: rv32_fetch_wdt (clear, enable, expired) holds the timeout counter.
//  FSM and datapath registers stay in rv32_ifetch.
// TESTING
//  1 pc_in=0x100, gnt same cycle, rvalid+1 with rdata=0x00A00093 -> imem_addr=0x100,
//    instr_valid 3 cycles after leaving IDLE, instr=0x00A00093, instr_pc=0x100, FETCH_OK.
//  2 gnt delayed 5 cycles (DMA contention) -> imem_req/imem_addr=0x104 held 6 cycles,
//    fetch_stall=1 throughout, single request.
//  3 pc_in=0x102 -> no imem_req, instr_valid with FETCH_MISALIGN, instr=0x00000013.
//  4 rvalid with imem_err=1 -> FETCH_BUSERR. No rvalid for 64 cycles -> FETCH_TIMEOUT.
//    rvalid at cycle 70 is ignored.
//  5 flush in WAIT, pc_in -> 0x200, stale rvalid(0xDEADBEEF) -> discarded;
//    next fetch has imem_addr=0x200, instr never shows 0xDEADBEEF.
//  6 rst_n asserted in REQ -> imem_req=0 immediately, all outputs at reset values;
//    after release, the first fetch goes to RESET_VECTOR.

Source files
------------

// File: rtl/rv32_ifetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_ifetch_pkg : shared types and constants for the instruction-fetch unit
// Rev 1.0
// ---------------------------------------------------------------------------
package rv32_ifetch_pkg;

  localparam int              XLEN         = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_1000;
  localparam logic [31:0]     NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FETCH_OK       = 2'd0,
    FETCH_MISALIGN = 2'd1,
    FETCH_BUSERR   = 2'd2,
    FETCH_TIMEOUT  = 2'd3
  } fetch_fault_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_fetch_wdt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_fetch_wdt : saturating watchdog counting cycles spent waiting for rvalid
// Rev 1.0
// ---------------------------------------------------------------------------
module rv32_fetch_wdt #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_CNT_W-1:0] C_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [TO_CNT_W-1:0] C_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expires in the final permitted wait cycle, so the count reaches the limit on that edge.
  assign o_expired = i_enable && (r_cnt >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/rv32_ifetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_ifetch : single-outstanding instruction fetch over a req/gnt/rvalid SRAM port
// Rev 1.0
// ---------------------------------------------------------------------------
module rv32_ifetch
  import rv32_ifetch_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            core_adv,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output fetch_fault_e    fault_cause,
  output logic            fetch_stall
);

  fetch_state_e    r_state, w_state_nx;
  logic [XLEN-1:0] r_addr,  w_addr_nx;
  logic [31:0]     r_instr, w_instr_nx;
  logic [XLEN-1:0] r_ipc,   w_ipc_nx;
  fetch_fault_e    r_fault, w_fault_nx;
  logic            r_drop,  w_drop_nx;
  logic            w_in_wait;
  logic            w_expired;

  assign w_in_wait = (r_state == WAIT);

  rv32_fetch_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_wdt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (!w_in_wait),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= RESET_VECTOR;
      r_instr <= NOP_INSTR;
      r_ipc   <= RESET_VECTOR;
      r_fault <= FETCH_OK;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_instr <= w_instr_nx;
      r_ipc   <= w_ipc_nx;
      r_fault <= w_fault_nx;
      r_drop  <= w_drop_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_instr_nx = r_instr;
    w_ipc_nx   = r_ipc;
    w_fault_nx = r_fault;
    w_drop_nx  = r_drop;
    unique case (r_state)
      IDLE: begin
        if (!flush && fetch_en) begin
          w_ipc_nx = pc_in;
          if (is_misaligned(pc_in)) begin
            w_instr_nx = NOP_INSTR;
            w_fault_nx = FETCH_MISALIGN;
            w_state_nx = VALID;
          end else begin
            w_addr_nx  = pc_in;
            w_state_nx = REQ;
          end
        end
      end
      REQ: begin
        // The request stays up until granted even when flushed; the response is dropped later.
        if (flush) w_drop_nx = 1'b1;
        if (imem_gnt) w_state_nx = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_drop_nx = 1'b0;
          if (r_drop || flush) begin
            w_state_nx = IDLE;
          end else begin
            w_instr_nx = imem_err ? NOP_INSTR : imem_rdata;
            w_fault_nx = imem_err ? FETCH_BUSERR : FETCH_OK;
            w_state_nx = VALID;
          end
        end else if (w_expired) begin
          w_drop_nx = 1'b0;
          if (r_drop || flush) begin
            w_state_nx = IDLE;
          end else begin
            w_instr_nx = NOP_INSTR;
            w_fault_nx = FETCH_TIMEOUT;
            w_state_nx = VALID;
          end
        end else if (flush) begin
          w_drop_nx = 1'b1;
        end
      end
      VALID: begin
        if (flush || core_adv) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_valid = (r_state == VALID);
  assign fault_cause = r_fault;
  assign fetch_stall = (r_state != VALID);

endmodule
`default_nettype wire
